// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the 3-requester memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int         NUM_REQ  = 3;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [1:0] LAST_RST = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Successor in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin pick: scans last+1, last+2, last (mod 3) and returns the first request.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_last,
  output logic               o_vld,
  output logic [1:0]         o_idx
);
  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0 = next_idx(i_last);
  assign w_c1 = next_idx(w_c0);
  assign w_c2 = i_last;

  always_comb begin
    o_vld = 1'b1;
    o_idx = SEL_NONE;
    if (i_req[w_c0])      o_idx = w_c0;
    else if (i_req[w_c1]) o_idx = w_c1;
    else if (i_req[w_c2]) o_idx = w_c2;
    else                  o_vld = 1'b0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin IDLE/BUSY sequencer sharing one memory port among IF, MEM and DMA; all outputs registered.
// Define ARB_TIMEOUT_EN to abort a BUSY transfer with err_o after TIMEOUT cycles without mem_ack_i.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               mem_ack_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         sel_o,
  output logic               mem_req_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               busy_o,
  output logic               err_o
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt,     w_gnt_nxt;
  logic [1:0]         r_sel,     w_sel_nxt;
  logic               r_mem_req, w_mem_req_nxt;
  logic [NUM_REQ-1:0] r_done,    w_done_nxt;
  logic               r_busy,    w_busy_nxt;
  logic               r_err,     w_err_nxt;
  logic [1:0]         r_last,    w_last_nxt;

  logic               w_pick_vld;
  logic [1:0]         w_pick_idx;
  logic               w_timeout;
  logic               w_finish;

  // A requester being told "done" this cycle must not be re-granted on the same edge.
  mem_port_arbiter_rr_pick u_rr_pick (
    .i_req  (req_i & ~r_done),
    .i_last (r_last),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                  r_cnt <= '0;
    else if (r_state == ST_IDLE) r_cnt <= '0;
    else if (!mem_ack_i)         r_cnt <= r_cnt + CNT_W'(1);
  end

  // Fires on the TIMEOUT-th ack-less BUSY cycle; an ack in that cycle takes precedence.
  assign w_timeout = (r_state == ST_BUSY) && !mem_ack_i && (r_cnt == TO_LAST);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TO_LAST;
  assign w_timeout    = 1'b0;
`endif

  assign w_finish = (r_state == ST_BUSY) && (mem_ack_i || w_timeout);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_sel     <= SEL_NONE;
      r_mem_req <= 1'b0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= LAST_RST;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_err     <= w_err_nxt;
      r_last    <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_finish)   w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_mem_req_nxt = r_mem_req;
    w_busy_nxt    = r_busy;
    w_last_nxt    = r_last;
    w_done_nxt    = '0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt     = idx2onehot(w_pick_idx);
          w_sel_nxt     = w_pick_idx;
          w_mem_req_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
        end else begin
          w_gnt_nxt     = '0;
          w_sel_nxt     = SEL_NONE;
          w_mem_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
        end
      end
      ST_BUSY: begin
        // Grant stays frozen (r_sel holds the owner) until ack or timeout.
        if (w_finish) begin
          w_done_nxt    = idx2onehot(r_sel);
          w_err_nxt     = w_timeout;
          w_last_nxt    = r_sel;
          w_gnt_nxt     = '0;
          w_sel_nxt     = SEL_NONE;
          w_mem_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
        end
      end
      default: begin
        w_gnt_nxt     = '0;
        w_sel_nxt     = SEL_NONE;
        w_mem_req_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  assign gnt_o     = r_gnt;
  assign sel_o     = r_sel;
  assign mem_req_o = r_mem_req;
  assign done_o    = r_done;
  assign busy_o    = r_busy;
  assign err_o     = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mem_port_arbiter;
  localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [10:0] RST_OUT = {3'b000, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0};

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] req_i;
  logic       mem_ack_i;
  logic [2:0] gnt_o;
  logic [1:0] sel_o;
  logic       mem_req_o;
  logic [2:0] done_o;
  logic       busy_o;
  logic       err_o;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_busy;
  int         m_owner;
  int         m_last;
  int         m_cnt;
  logic [2:0] m_done;
  bit         m_err;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .mem_ack_i (mem_ack_i),
    .gnt_o     (gnt_o),
    .sel_o     (sel_o),
    .mem_req_o (mem_req_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  assign obs = {gnt_o, sel_o, mem_req_o, done_o, busy_o, err_o};

  function automatic logic [10:0] m_out();
    logic [2:0] g;
    logic [1:0] s;
    g = m_busy ? 3'(1 << m_owner) : 3'b000;
    s = m_busy ? 2'(m_owner) : 2'b11;
    return {g, s, m_busy, m_done, m_busy, m_err};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 2; m_cnt = 0; m_done = '0; m_err = 0;
  endtask

  // One arbitration decision, from the current inputs and the model's own view of the port.
  task automatic model_next();
    logic [2:0] elig;
    bit found;
    int c;
    if (!m_busy) begin
      elig  = req_i & ~m_done;
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (!found && elig[c]) begin found = 1; m_owner = c; end
      end
      m_done = '0; m_err = 0;
      if (found) begin m_busy = 1; m_cnt = 0; end
    end else begin
      m_done = '0; m_err = 0;
      if (mem_ack_i) begin
        m_done = 3'(1 << m_owner); m_last = m_owner; m_busy = 0;
      end else if (TO_EN && (m_cnt + 1 >= TMO)) begin
        m_done = 3'(1 << m_owner); m_err = 1; m_last = m_owner; m_busy = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; req_i = '0; mem_ack_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = '0; mem_ack_i = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if (obs !== RST_OUT) begin n_bad++; $display("FAIL reset_vals: got %b want %b", obs, RST_OUT); end
    @(posedge clk_i); #1;
    rst_i = 1'b1; req_i = 3'b111;
    step();
    n_cmp++;
    if (gnt_o !== 3'b001 || obs !== m_out()) begin n_bad++; $display("FAIL reset_first_gnt: got %b want %b", obs, m_out()); end
    step();
    #2; rst_i = 1'b0; #1;
    model_reset();
    n_cmp++;
    if (obs !== RST_OUT) begin n_bad++; $display("FAIL reset_mid_busy: got %b want %b", obs, RST_OUT); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    step();
    n_cmp++;
    if (gnt_o !== 3'b001 || done_o !== 3'b000) begin n_bad++; $display("FAIL reset_regrant: gnt %b done %b want 001 000", gnt_o, done_o); end
  endtask

  task automatic test_single();
    do_reset();
    req_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      mem_ack_i = (i == 2);
      if (i == 2) begin end
      if (i == 0) mem_ack_i = 1'b0;
      if (i > 0) begin end
      if (i == 0) begin
        step();
      end else begin
        mem_ack_i = 1'b0;
        step();
      end
      n_cmp++;
      if (sel_o !== 2'b01 || obs !== m_out()) begin n_bad++; $display("FAIL single_sel c%0d: got %b want %b", i, obs, m_out()); end
    end
    mem_ack_i = 1'b1;
    step();
    n_cmp++;
    if (done_o !== 3'b010 || sel_o !== 2'b11 || obs !== m_out()) begin n_bad++; $display("FAIL single_done: got %b want %b", obs, m_out()); end
    mem_ack_i = 1'b0; req_i = '0;
    step();
    n_cmp++;
    if (done_o !== 3'b000 || obs !== m_out()) begin n_bad++; $display("FAIL single_after: got %b want %b", obs, m_out()); end
  endtask

  task automatic test_fairness();
    logic [2:0] want;
    do_reset();
    req_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      want = 3'b001 << (i % 3);
      step();
      n_cmp++;
      if (gnt_o !== want || obs !== m_out()) begin n_bad++; $display("FAIL fair_gnt %0d: got %b want gnt %b", i, gnt_o, want); end
      mem_ack_i = 1'b1;
      step();
      mem_ack_i = 1'b0;
      n_cmp++;
      if (done_o !== want || busy_o !== 1'b0 || obs !== m_out()) begin n_bad++; $display("FAIL fair_idle %0d: got %b want %b", i, obs, m_out()); end
    end
    req_i = '0;
  endtask

  task automatic test_hold_done();
    do_reset();
    req_i = 3'b001;
    step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    n_cmp++;
    if (done_o !== 3'b001) begin n_bad++; $display("FAIL hold_done: got %b want 001", done_o); end
    step();
    n_cmp++;
    if (busy_o !== 1'b0 || gnt_o !== 3'b000 || obs !== m_out()) begin n_bad++; $display("FAIL hold_no_regrant: got %b want %b", obs, m_out()); end
    step();
    n_cmp++;
    if (gnt_o !== 3'b001 || obs !== m_out()) begin n_bad++; $display("FAIL hold_regrant: got %b want %b", obs, m_out()); end
    req_i = '0; mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    mem_ack_i = 1'b1;
    step();
    step();
    n_cmp++;
    if (obs !== RST_OUT || obs !== m_out()) begin n_bad++; $display("FAIL spur_ack_idle: got %b want %b", obs, RST_OUT); end
    mem_ack_i = 1'b0; req_i = 3'b100;
    step();
    req_i = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (busy_o !== 1'b1 || gnt_o !== 3'b100 || obs !== m_out()) begin n_bad++; $display("FAIL spur_drop %0d: got %b want %b", i, obs, m_out()); end
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    n_cmp++;
    if (done_o !== 3'b100 || obs !== m_out()) begin n_bad++; $display("FAIL spur_done: got %b want %b", obs, m_out()); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_i = 3'b010;
    step();
    for (int i = 1; i <= TMO; i++) begin
      step();
      n_cmp++;
      if (obs !== m_out() || err_o !== (i == TMO) || done_o !== ((i == TMO) ? 3'b010 : 3'b000)) begin
        n_bad++; $display("FAIL tmo_abort %0d: got %b want %b", i, obs, m_out());
      end
    end
    req_i = 3'b001;
    step();
    n_cmp++;
    if (err_o !== 1'b0 || gnt_o !== 3'b000) begin n_bad++; $display("FAIL tmo_err_pulse: err %b gnt %b want 0 000", err_o, gnt_o); end
    step();
    for (int i = 1; i < TMO; i++) step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    n_cmp++;
    if (done_o !== 3'b001 || err_o !== 1'b0 || obs !== m_out()) begin n_bad++; $display("FAIL tmo_ack_wins: got %b want %b", obs, m_out()); end
    req_i = '0;
    step();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req_i = 3'b001;
    step();
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if (busy_o !== 1'b1 || err_o !== 1'b0 || obs !== m_out()) begin n_bad++; $display("FAIL no_tmo_wait: got %b want %b", obs, m_out()); end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0; req_i = '0;
    n_cmp++;
    if (done_o !== 3'b001 || err_o !== 1'b0) begin n_bad++; $display("FAIL no_tmo_done: got %b want done 001", obs); end
  endtask
`endif

  task automatic test_random();
    int bad_here;
    do_reset();
    bad_here = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (m_done[r])    req_i[r] = ($urandom_range(0, 1) == 1);
        else if (!req_i[r]) req_i[r] = ($urandom_range(0, 2) == 0);
      end
      mem_ack_i = ($urandom_range(0, 9) < 3);
      step();
      n_cmp++;
      if (obs !== m_out()) begin
        n_bad++;
        if (bad_here < 5) $display("FAIL random cyc%0d: got %b want %b", cyc, obs, m_out());
        bad_here++;
      end
    end
    req_i = '0; mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; req_i = '0; mem_ack_i = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_hold_done();
    test_spurious();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
